// File: rtl/ps2_note_pkg.sv
// Shared types and constants for the PS/2 note receiver: frame states,
// scan-code prefixes and the key-to-frequency table.
package ps2_note_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } frame_state_e;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    localparam int unsigned KEY_COUNT = 8;

    localparam logic [7:0] KEY_CODE [KEY_COUNT] = '{
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42
    };

    localparam int unsigned KEY_HZ [KEY_COUNT] = '{
        262, 294, 330, 349, 392, 440, 494, 523
    };

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one PS/2 line;
// also flags the cycle in which the filtered level falls.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             fall_q;

    // cnt_q counts consecutive synchronised samples that disagree with level_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                fall_q  <= level_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_note_receiver.sv
// PS/2 keyboard frame receiver with a make/break decoder that turns a small
// set of keys into a tone half-period (last key pressed wins).
module ps2_note_receiver
    import ps2_note_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100_000,
    parameter int unsigned NOTE_W      = 18
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ps2c,
    input  logic              ps2d,
    output logic              code_valid,
    output logic [7:0]        code_byte,
    output logic              frame_err,
    output logic              note_on,
    output logic [NOTE_W-1:0] FinalNote
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic c_fall, c_level, d_level, d_fall;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk   (CLK),
        .rst_n (RSTn),
        .raw   (ps2c),
        .level (c_level),
        .fall  (c_fall)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk   (CLK),
        .rst_n (RSTn),
        .raw   (ps2d),
        .level (d_level),
        .fall  (d_fall)
    );

    logic unused_ok;
    assign unused_ok = ^{c_level, d_fall};

    // Half-period table, fixed at elaboration
    logic [NOTE_W-1:0] period_tab [KEY_COUNT];

    for (genvar g = 0; g < KEY_COUNT; g++) begin : g_tab
        localparam longint unsigned PERIOD = longint'(CLK_HZ) / (2 * longint'(KEY_HZ[g]));
        if (PERIOD > ((64'd1 << NOTE_W) - 64'd1)) begin : g_too_wide
            $error("note period does not fit in NOTE_W bits");
        end
        assign period_tab[g] = PERIOD[NOTE_W-1:0];
    end

    frame_state_e state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             par;
    logic [TMO_W-1:0] tmo;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= StIdle;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            code_byte  <= '0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == StIdle) begin
                tmo <= '0;
                if (c_fall && !d_level) begin
                    state   <= StData;
                    bit_cnt <= '0;
                end
            end else if (c_fall) begin
                tmo <= '0;
                case (state)
                    StData: begin
                        shift   <= {d_level, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= StParity;
                    end
                    StParity: begin
                        par   <= d_level;
                        state <= StStop;
                    end
                    StStop: begin
                        state <= StIdle;
                        if ((^{shift, par}) && d_level) begin
                            code_valid <= 1'b1;
                            code_byte  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                state     <= StIdle;
                frame_err <= 1'b1;
                tmo       <= '0;
            end else begin
                tmo <= tmo + TMO_W'(1);
            end
        end
    end

    logic       key_hit;
    logic [2:0] key_idx;

    always_comb begin
        key_hit = 1'b0;
        key_idx = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (code_byte == KEY_CODE[i]) begin
                key_hit = 1'b1;
                key_idx = 3'(i);
            end
        end
    end

    logic       brk_pend, ext_pend;
    logic [7:0] held_key;
    logic       is_held;

    assign is_held = note_on && (held_key == code_byte);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            held_key  <= '0;
            note_on   <= 1'b0;
            FinalNote <= '0;
        end else if (code_valid) begin
            if (code_byte == CODE_BREAK) begin
                brk_pend <= 1'b1;
            end else if (code_byte == CODE_EXT) begin
                ext_pend <= 1'b1;
            end else begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
                // Extended codes never touch the note outputs
                if (!ext_pend && key_hit) begin
                    if (!brk_pend) begin
                        if (!is_held) begin
                            note_on   <= 1'b1;
                            FinalNote <= period_tab[key_idx];
                            held_key  <= code_byte;
                        end
                    end else if (is_held) begin
                        note_on   <= 1'b0;
                        FinalNote <= '0;
                    end
                end
            end
        end
    end

endmodule
